seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment driver for the board's anode-scanned display. It shows DIGITS hex nibbles with per-digit decimal points and optional leading-zero blanking. Scan timing comes from an internal clock-enable counter, not a derived clock. A double-buffered value register, with a load strobe, updates the display only at frame boundaries so the display never tears. It sits beside the CPU and shows the address bus, data bus or PC.

Parameters:
DIGITS, 4, number of digits/anodes; must be >= 1.
REFRESH_DIV, 12500, clk cycles per digit slot (50 MHz gives 4 kHz per digit, 1 kHz frame); must be >= 2.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  scan enable; 0 = display dark and scan held at start
value  in  4*DIGITS  hex nibbles; nibble i drives digit i; digit DIGITS-1 is most significant
dp_in  in  DIGITS  decimal point request per digit; 1 = lit; sampled live, not buffered
blank_lz  in  1  1 = suppress leading zeros
load  in  1  single-cycle strobe; captures value into the shadow register
seg_n  out  7  segment cathodes {g,f,e,d,c,b,a}, active low
dp_n  out  1  decimal point cathode, active low
an_n  out  DIGITS  digit anodes, one-hot active low
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, reset_n=0):
  - seg_n=7'h7F, dp_n=1, an_n all 1, frame_done=0.
  - slot counter cnt=0, digit index dig=0.
  - shadow=0, active=0, pending=0.
- Counters, when enable=1:
  - cnt counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - When cnt==REFRESH_DIV-1: cnt->0 and dig advances. dig wraps DIGITS-1 -> 0.
  - Frame wrap is the terminal count while dig==DIGITS-1.
- enable=0:
  - cnt=0 and dig=0 forced synchronously.
  - Registered outputs go dark (an_n all 1, seg_n=7'h7F, dp_n=1) on the next edge.
  - No frame_done pulses. Shadow and load handling continue.
- Load and double buffer:
  - load=1 -> shadow<=value, pending<=1. A later load before the frame wrap overwrites shadow (last one wins).
  - At frame wrap with pending=1 -> active<=shadow, pending<=0.
  - load coinciding with frame wrap -> active<=value directly (bypass), pending<=0.
  - frame_done=1 for exactly the cycle after the wrap edge, whether or not a transfer happened.
- Outputs: all registered, one cycle behind (cnt, dig).
  - cnt < BLANK_CYCLES -> an_n all 1.
  - Otherwise an_n[dig]=0 and the rest are 1.
  - seg_n = hex pattern of active nibble dig:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0011000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - dp_n = ~dp_in[dig].
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked when active nibbles i..DIGITS-1 are all zero.
  - Blanked means seg_n=7'h7F; the anode is still driven.
  - Digit 0 is never blanked.
  - The decimal point is unaffected by blanking.
- DIGITS=1: dig is constant 0 and every slot terminal count is a frame wrap.
- Reset mid-frame: immediate return to reset state; a pending shadow is discarded.

Decomposition:
- Package seg7_pkg:
  - seg7_t (7-bit active-low pattern) typedef.
  - SEG7_BLANK=7'h7F.
  - The 16 hex pattern constants.
- Sub-module seg7_hex_decoder: combinational 4-bit -> seg7_t, reusable elsewhere.
- seg7_scan_driver instantiates one seg7_hex_decoder on the muxed nibble.

Test Plan:
(Bench parameters: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.)
- Reset: hold reset_n=0 mid-scan -> an_n=4'hF, seg_n=7'h7F, dp_n=1 immediately. Release with enable=1 -> an_n[0]=0 first seen 3 cycles after release; digits scan 0,1,2,3 with 8-cycle slots.
- Buffered load: load=1 with value=16'hA0F3, then change value=16'h1111 with no load. Shown nibbles stay 0 until the next frame_done. After it: digit0 seg_n=0110000 (3), digit1 0001110 (F), digit2 1000000 (0), digit3 0001000 (A).
- Leading-zero blanking: blank_lz=1, load 16'h0042 -> digits 3 and 2 have seg_n=7'h7F with anodes still driven; digit1=0011001 (4), digit0=0100100 (2). Load 16'h0000 -> only digit0 shows 1000000.
- Load collision: load 16'h1234 on the exact wrap cycle -> the frame starting next shows 1234. Two loads 16'h5555 then 16'h6666 within one frame -> next frame shows 6666.
- Dark scan and decimal points: enable=0 for 20 cycles -> an_n=4'hF and no frame_done. Re-enable -> scan restarts at digit0. dp_in=4'b0100 -> dp_n=0 only during digit2's lit window.
- Frame timing: frame_done period exactly 32 cycles. Each anode low exactly 6 consecutive cycles per slot; never two anodes low at once.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment types and hex glyph constants
package seg7_pkg;

  // Active-low cathode pattern, bit order {g,f,e,d,c,b,a}
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  localparam seg7_t SEG7_HEX_0 = 7'h40;
  localparam seg7_t SEG7_HEX_1 = 7'h79;
  localparam seg7_t SEG7_HEX_2 = 7'h24;
  localparam seg7_t SEG7_HEX_3 = 7'h30;
  localparam seg7_t SEG7_HEX_4 = 7'h19;
  localparam seg7_t SEG7_HEX_5 = 7'h12;
  localparam seg7_t SEG7_HEX_6 = 7'h02;
  localparam seg7_t SEG7_HEX_7 = 7'h78;
  localparam seg7_t SEG7_HEX_8 = 7'h00;
  localparam seg7_t SEG7_HEX_9 = 7'h18;
  localparam seg7_t SEG7_HEX_A = 7'h08;
  localparam seg7_t SEG7_HEX_B = 7'h03;
  localparam seg7_t SEG7_HEX_C = 7'h46;
  localparam seg7_t SEG7_HEX_D = 7'h21;
  localparam seg7_t SEG7_HEX_E = 7'h06;
  localparam seg7_t SEG7_HEX_F = 7'h0E;

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex nibble to active-low segment glyph
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_n_o
);

  always_comb begin
    seg_n_o = SEG7_BLANK;
    case (nibble_i)
      4'h0: seg_n_o = SEG7_HEX_0;
      4'h1: seg_n_o = SEG7_HEX_1;
      4'h2: seg_n_o = SEG7_HEX_2;
      4'h3: seg_n_o = SEG7_HEX_3;
      4'h4: seg_n_o = SEG7_HEX_4;
      4'h5: seg_n_o = SEG7_HEX_5;
      4'h6: seg_n_o = SEG7_HEX_6;
      4'h7: seg_n_o = SEG7_HEX_7;
      4'h8: seg_n_o = SEG7_HEX_8;
      4'h9: seg_n_o = SEG7_HEX_9;
      4'hA: seg_n_o = SEG7_HEX_A;
      4'hB: seg_n_o = SEG7_HEX_B;
      4'hC: seg_n_o = SEG7_HEX_C;
      4'hD: seg_n_o = SEG7_HEX_D;
      4'hE: seg_n_o = SEG7_HEX_E;
      default: seg_n_o = SEG7_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - anode-scanned multi-digit hex display with frame-synchronous double buffer
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output seg7_t                 seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                pending_q, pending_d;
  seg7_t               seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                term, wrap, acc;
  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          nibble;
  seg7_t               glyph;

  assign nibble = active_q[{dig_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble_i (nibble),
    .seg_n_o  (glyph)
  );

  // zero_from[i]: every active nibble from i up to the most significant is zero
  always_comb begin
    zero_from = '0;
    acc       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (active_q[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    an_d      = '1;
    seg_d     = SEG7_BLANK;
    dp_d      = 1'b1;
    term      = enable && (cnt_q == CNT_LAST);
    wrap      = term && (dig_q == DIG_LAST);
    frame_d   = wrap;

    if (!enable) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (term) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
    // A load on the wrap edge bypasses the shadow so it is not delayed a frame
    if (wrap) begin
      pending_d = 1'b0;
      if (load)           active_d = value;
      else if (pending_q) active_d = shadow_q;
    end

    if (enable) begin
      if (cnt_q >= CNT_BLANK) an_d = ~(DIGITS'(1) << dig_q);
      seg_d = (blank_lz && (dig_q != '0) && zero_from[dig_q]) ? SEG7_BLANK : glyph;
      dp_d  = ~dp_in[dig_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG7_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  seg7_scan_driver #(
    .DIGITS       (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    tick();
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 100), 32'd1);
  endtask

  task automatic wait_digit(input int d, input string tag, input logic [6:0] exp_seg);
    int n;
    logic [3:0] want;
    want = ~(4'b0001 << d);
    n = 0;
    while (an_n !== want && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_anode"}, 32'(n < 100), 32'd1);
    chk(tag, 32'(seg_n), 32'(exp_seg));
  endtask

  initial begin
    int n, bad, lit2, overlap;
    int lows [4];

    reset_n = 1'b0; enable = 1'b1; value = 16'h0; dp_in = 4'h0;
    blank_lz = 1'b0; load = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (12) tick();
    chk("pre_reset_an", 32'(an_n), 32'hD);

    // asynchronous reset mid-scan
    #2 reset_n = 1'b0;
    #1;
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_dp", 32'(dp_n), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rel_edge1_an", 32'(an_n), 32'hF);
    tick();
    chk("rel_edge2_an", 32'(an_n), 32'hF);
    tick();
    chk("rel_edge3_an", 32'(an_n), 32'hE);
    chk("rel_edge3_seg", 32'(seg_n), 32'h40);
    wait_digit(1, "scan_d1", 7'h40);
    wait_digit(2, "scan_d2", 7'h40);
    wait_digit(3, "scan_d3", 7'h40);

    // frame period and anode window shape
    wait_frame("fd_wait0");
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    chk("frame_period", 32'(n), 32'd32);
    for (int i = 0; i < 4; i++) lows[i] = 0;
    overlap = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if ($countones(~an_n) > 1) overlap++;
      for (int i = 0; i < 4; i++) if (an_n[i] == 1'b0) lows[i]++;
    end
    chk("anode_overlap", 32'(overlap), 32'd0);
    chk("an0_low_cycles", 32'(lows[0]), 32'd6);
    chk("an3_low_cycles", 32'(lows[3]), 32'd6);

    // buffered load: nothing changes until the frame wrap
    wait_frame("fd_wait1");
    value = 16'hA0F3; load = 1'b1;
    tick();
    load = 1'b0; value = 16'h1111;
    wait_digit(2, "buf_hold_d2", 7'h40);
    wait_digit(3, "buf_hold_d3", 7'h40);
    wait_frame("fd_wait2");
    wait_digit(0, "buf_d0", 7'h30);
    wait_digit(1, "buf_d1", 7'h0E);
    wait_digit(2, "buf_d2", 7'h40);
    wait_digit(3, "buf_d3", 7'h08);

    // leading-zero blanking
    blank_lz = 1'b1;
    wait_frame("fd_wait3");
    value = 16'h0042; load = 1'b1;
    tick();
    load = 1'b0;
    wait_frame("fd_wait4");
    wait_digit(0, "lz42_d0", 7'h24);
    wait_digit(1, "lz42_d1", 7'h19);
    wait_digit(2, "lz42_d2", 7'h7F);
    wait_digit(3, "lz42_d3", 7'h7F);
    wait_frame("fd_wait5");
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    wait_frame("fd_wait6");
    wait_digit(0, "lz0_d0", 7'h40);
    wait_digit(1, "lz0_d1", 7'h7F);
    wait_digit(3, "lz0_d3", 7'h7F);
    blank_lz = 1'b0;

    // load on the exact wrap edge bypasses the shadow
    wait_frame("fd_wait7");
    repeat (31) tick();
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    chk("coll_fd", 32'(frame_done), 32'h1);
    wait_digit(0, "coll_d0", 7'h19);
    wait_digit(1, "coll_d1", 7'h30);
    wait_digit(2, "coll_d2", 7'h24);
    wait_digit(3, "coll_d3", 7'h79);

    // last load within a frame wins
    wait_frame("fd_wait8");
    value = 16'h5555; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    value = 16'h6666; load = 1'b1;
    tick();
    load = 1'b0;
    wait_frame("fd_wait9");
    wait_digit(0, "two_d0", 7'h02);
    wait_digit(3, "two_d3", 7'h02);

    // dark scan
    wait_frame("fd_wait10");
    enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (an_n !== 4'hF || frame_done !== 1'b0 || seg_n !== 7'h7F || dp_n !== 1'b1) bad++;
    end
    chk("dark_cycles_bad", 32'(bad), 32'd0);

    // restart at digit 0 with a decimal point on digit 2
    dp_in = 4'b0100;
    enable = 1'b1;
    tick();
    chk("restart_e1_an", 32'(an_n), 32'hF);
    tick();
    tick();
    chk("restart_an", 32'(an_n), 32'hE);
    chk("restart_dp", 32'(dp_n), 32'h1);
    bad = 0;
    lit2 = 0;
    for (int c = 0; c < 29; c++) begin
      tick();
      if (an_n == 4'hB) begin
        lit2++;
        if (dp_n !== 1'b0) bad++;
      end else if (an_n != 4'hF) begin
        if (dp_n !== 1'b1) bad++;
      end
    end
    chk("dp_bad", 32'(bad), 32'd0);
    chk("dp_d2_lit_cycles", 32'(lit2), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
